aftab_mem_read_sequencer: RTL and testbench



---
 rtl/aftab_mem_pkg.sv | 37 +++
 rtl/aftab_opt_adder.sv | 12 +
 rtl/aftab_mem_read_sequencer.sv | 101 ++++++++++
 tb/tb_aftab_mem_read_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aftab_mem_pkg.sv
// Shared definitions for the AFTAB byte-serial memory read path: state
// encoding, load-size codes and the size/extension helpers.
package aftab_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] NBYTES_1 = 2'b00;
    localparam logic [1:0] NBYTES_2 = 2'b01;
    localparam logic [1:0] NBYTES_4 = 2'b11;

    // Index of the final byte lane; the unused code 2'b10 behaves as a word.
    function automatic logic [1:0] last_index(input logic [1:0] nbytes);
        case (nbytes)
            NBYTES_1: last_index = 2'd0;
            NBYTES_2: last_index = 2'd1;
            default:  last_index = 2'd3;
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [31:0] buffer,
                                                input logic [1:0]  last_idx,
                                                input logic        is_unsigned);
        logic [31:0] result;
        result = buffer;
        case (last_idx)
            2'd0:    result[31:8]  = {24{buffer[7]  & ~is_unsigned}};
            2'd1:    result[31:16] = {16{buffer[15] & ~is_unsigned}};
            default: result = buffer;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/aftab_opt_adder.sv
// Address-increment adder: sum = a + b, modulo 2^len.
module aftab_opt_adder #(
    parameter int len = 32
) (
    input  logic [len-1:0] a,
    input  logic [1:0]     b,
    output logic [len-1:0] sum
);

    assign sum = a + len'(b);

endmodule

// File: rtl/aftab_mem_read_sequencer.sv
// Byte-serial load sequencer: one byte per memory handshake, assembled
// little-endian and sign/zero-extended to 32 bits.
module aftab_mem_read_sequencer
    import aftab_mem_pkg::*;
#(
    parameter int len = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           startRead,
    input  logic [len-1:0] addrIn,
    input  logic [1:0]     nBytes,
    input  logic           loadUnsigned,
    input  logic           memReady,
    input  logic [7:0]     memDataIn,
    output logic           memRead,
    output logic [len-1:0] memAddr,
    output logic [31:0]    dataOut,
    output logic           completeRead,
    output logic           busy
);

    state_t         state_reg, state_next;
    logic [len-1:0] addr_reg, addr_next, addr_inc;
    logic [1:0]     byte_cnt_reg, byte_cnt_next;
    logic [1:0]     last_idx_reg, last_idx_next;
    logic           unsigned_reg, unsigned_next;
    logic [31:0]    buffer_reg, buffer_next;

    aftab_opt_adder #(.len(len)) u_addr_inc (
        .a   (addr_reg),
        .b   (2'b01),
        .sum (addr_inc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            byte_cnt_reg <= 2'd0;
            last_idx_reg <= 2'd0;
            unsigned_reg <= 1'b0;
            buffer_reg   <= 32'd0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            byte_cnt_reg <= byte_cnt_next;
            last_idx_reg <= last_idx_next;
            unsigned_reg <= unsigned_next;
            buffer_reg   <= buffer_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        byte_cnt_next = byte_cnt_reg;
        last_idx_next = last_idx_reg;
        unsigned_next = unsigned_reg;
        buffer_next   = buffer_reg;
        memRead       = 1'b0;
        completeRead  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (startRead) begin
                    addr_next     = addrIn;
                    last_idx_next = last_index(nBytes);
                    unsigned_next = loadUnsigned;
                    byte_cnt_next = 2'd0;
                    buffer_next   = 32'd0;
                    state_next    = REQ;
                end
            end
            REQ: begin
                memRead = 1'b1;
                if (memReady) begin
                    for (int i = 0; i < 4; i++) begin
                        if (byte_cnt_reg == 2'(i))
                            buffer_next[8*i +: 8] = memDataIn;
                    end
                    addr_next = addr_inc;
                    if (byte_cnt_reg == last_idx_reg)
                        state_next = DONE;
                    else
                        byte_cnt_next = byte_cnt_reg + 2'd1;
                end
            end
            DONE: begin
                completeRead = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The buffer is only cleared by a new request, so the result holds after DONE.
    assign dataOut = extend_load(buffer_reg, last_idx_reg, unsigned_reg);
    assign memAddr = addr_reg;
    assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_aftab_mem_read_sequencer.sv
// Scoreboard bench for aftab_mem_read_sequencer: directed and random loads
// against a byte-level memory model and a reference load-value calculation.
module tb_aftab_mem_read_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        startRead = 1'b0;
    logic [31:0] addrIn = 32'd0;
    logic [1:0]  nBytes = 2'd0;
    logic        loadUnsigned = 1'b0;
    logic        memReady = 1'b0;
    logic [7:0]  memDataIn = 8'd0;
    logic        memRead;
    logic [31:0] memAddr;
    logic [31:0] dataOut;
    logic        completeRead;
    logic        busy;

    aftab_mem_read_sequencer #(.len(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .startRead    (startRead),
        .addrIn       (addrIn),
        .nBytes       (nBytes),
        .loadUnsigned (loadUnsigned),
        .memReady     (memReady),
        .memDataIn    (memDataIn),
        .memRead      (memRead),
        .memAddr      (memAddr),
        .dataOut      (dataOut),
        .completeRead (completeRead),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          n;
        logic [31:0] data;
        int          start;
    } txn_t;

    txn_t        exp_q[$];
    logic [7:0]  mem [logic [31:0]];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wait_mode = 0;
    int          waits_left = 0;
    int          mon_idx = 0;
    int          mon_waits = 0;

    always @(posedge clk) cyc++;

    function automatic int size_of(input logic [1:0] nb);
        return (nb == 2'b00) ? 1 : (nb == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] bw, input int n, input bit uns);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = bw[8*i +: 8];
        if (!uns && n < 4 && r[8*n-1])
            for (int k = 8*n; k < 32; k++) r[k] = 1'b1;
        return r;
    endfunction

    function automatic int first_waits(input int mode);
        return (mode == 1) ? 2 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Memory responder: drives memReady with the selected wait pattern.
    always @(posedge clk) begin
        #1;
        if (memRead) begin
            if (waits_left > 0) begin
                memReady = 1'b0;
                memDataIn = 8'($urandom);
                waits_left--;
            end else begin
                memReady = 1'b1;
                memDataIn = mem.exists(memAddr) ? mem[memAddr] : 8'h00;
                waits_left = first_waits(wait_mode);
            end
        end else begin
            memReady = 1'($urandom_range(0, 1));
            memDataIn = 8'($urandom);
        end
    end

    // Monitor: compares handshake addresses, completion data and latency.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            mon_idx = 0;
            mon_waits = 0;
        end else begin
            check("busy", 32'(busy), 32'(exp_q.size() != 0));
            if (memRead) begin
                if (exp_q.size() == 0) begin
                    check("spurious_memRead", 32'(memRead), 32'd0);
                end else begin
                    check("memAddr", memAddr, exp_q[0].addr + 32'(mon_idx));
                    if (memReady) mon_idx++;
                    else mon_waits++;
                end
            end
            if (completeRead) begin
                if (exp_q.size() == 0) begin
                    check("spurious_completeRead", 32'(completeRead), 32'd0);
                end else begin
                    txn_t t;
                    t = exp_q.pop_front();
                    check("dataOut", dataOut, t.data);
                    check("byte_count", 32'(mon_idx), 32'(t.n));
                    check("latency", 32'(cyc - t.start), 32'(t.n + mon_waits));
                    $display("load addr=%h n=%0d data=%h exp=%h waits=%0d", t.addr, t.n, dataOut, t.data, mon_waits);
                end
                mon_idx = 0;
                mon_waits = 0;
            end
        end
    end

    task automatic do_load(input logic [31:0] a, input logic [1:0] nb, input bit uns,
                           input logic [31:0] bw, input int wmode,
                           input bit poke_busy, input bit poke_done);
        int n;
        txn_t t;
        logic [31:0] expv;
        bit seen;
        n = size_of(nb);
        for (int i = 0; i < n; i++) mem[a + 32'(i)] = bw[8*i +: 8];
        expv = ref_load(bw, n, uns);
        @(posedge clk); #1;
        wait_mode = wmode;
        waits_left = first_waits(wmode);
        addrIn = a; nBytes = nb; loadUnsigned = uns; startRead = 1'b1;
        @(posedge clk); #1;
        t.addr = a; t.n = n; t.data = expv; t.start = cyc;
        exp_q.push_back(t);
        startRead = 1'b0;
        addrIn = $urandom; nBytes = 2'($urandom); loadUnsigned = 1'($urandom);
        if (poke_busy) begin
            startRead = 1'b1;
            @(posedge clk); #1;
            startRead = 1'b0;
        end
        seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (completeRead) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!seen) begin
            check("completion_timeout", 32'd0, 32'd1);
            return;
        end
        if (poke_done) begin
            startRead = 1'b1;
            addrIn = $urandom;
        end
        @(posedge clk); #1;
        startRead = 1'b0;
        @(posedge clk); #1;
        check("dataOut_hold", dataOut, expv);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #12;
        check("rst_memRead", 32'(memRead), 32'd0);
        check("rst_memAddr", memAddr, 32'd0);
        check("rst_dataOut", dataOut, 32'd0);
        check("rst_completeRead", 32'(completeRead), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_load(32'h0000_0100, 2'b11, 1'b0, 32'h1234_5678, 0, 1'b0, 1'b0);
        do_load(32'h0000_0007, 2'b00, 1'b0, 32'h0000_0080, 0, 1'b0, 1'b0);
        do_load(32'h0000_0007, 2'b00, 1'b1, 32'h0000_0080, 0, 1'b0, 1'b0);
        do_load(32'h0000_0200, 2'b01, 1'b0, 32'h0000_FFFE, 1, 1'b0, 1'b0);
        do_load(32'hFFFF_FFFE, 2'b11, 1'b0, 32'hA1B2_C3D4, 0, 1'b0, 1'b0);
        do_load(32'h0000_0300, 2'b10, 1'b0, 32'h8765_4321, 1, 1'b1, 1'b1);
        do_load(32'h0000_0401, 2'b01, 1'b1, 32'h0000_8001, 0, 1'b1, 1'b0);

        // Abort a word load after two bytes with an asynchronous reset.
        for (int i = 0; i < 4; i++) mem[32'h500 + 32'(i)] = 8'(8'h11 * (i + 1));
        @(posedge clk); #1;
        wait_mode = 0; waits_left = 0;
        addrIn = 32'h500; nBytes = 2'b11; loadUnsigned = 1'b0; startRead = 1'b1;
        @(posedge clk); #1;
        startRead = 1'b0;
        begin
            txn_t t;
            t.addr = 32'h500; t.n = 4; t.data = 32'h4433_2211; t.start = cyc;
            exp_q.push_back(t);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_memRead", 32'(memRead), 32'd0);
        check("abort_dataOut", dataOut, 32'd0);
        check("abort_memAddr", memAddr, 32'd0);
        check("abort_completeRead", 32'(completeRead), 32'd0);
        $display("reset abort: busy=%0d memRead=%0d dataOut=%h", busy, memRead, dataOut);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);

        for (int r = 0; r < 25; r++) begin
            logic [31:0] a;
            a = (r % 5 == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3))) : $urandom;
            do_load(a, 2'($urandom), 1'($urandom), $urandom, 2,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        #1;
        check("pending_loads", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
